// File: rtl/alien_pkg.sv
// Shared constants and types for the alien matrix blocks.
// Used by the health tracker, the matrix drawer and the movement block.
package alien_pkg;

    localparam int ROWS      = 4;
    localparam int COLS      = 8;
    localparam int CELL_LOG2 = 5;

    localparam int ROW_W  = $clog2(ROWS);
    localparam int COL_W  = $clog2(COLS);
    localparam int MASK_W = ROWS * COLS;

    typedef logic [31:0] alien_mask_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        CLEARED  = 2'd2,
        WAIT_SOF = 2'd3
    } health_state_t;

    // Score for a kill, indexed by row; row 0 is the top row.
    localparam logic [6:0] ROW_POINTS [ROWS] = '{7'd40, 7'd30, 7'd20, 7'd10};

    localparam alien_mask_t FULL_MASK =
        alien_mask_t'((64'd1 << MASK_W) - 64'd1);

    localparam logic [5:0] FULL_COUNT = 6'(MASK_W);

endpackage

// File: rtl/alien_cell_decode.sv
// Maps a pixel offset from the matrix origin to an alien cell.
// Purely combinational; the matrix drawer uses it as well.
module alien_cell_decode
    import alien_pkg::*;
(
    input  logic [11:0]      i_dx,
    input  logic [11:0]      i_dy,
    output logic [ROW_W-1:0] o_row,
    output logic [COL_W-1:0] o_col,
    output logic             o_inRange
);

    logic [11:0] w_colFull;
    logic [11:0] w_rowFull;

    // Offsets are two's complement; bit 11 set means left of / above origin.
    assign w_colFull = i_dx >> CELL_LOG2;
    assign w_rowFull = i_dy >> CELL_LOG2;

    assign o_col = w_colFull[COL_W-1:0];
    assign o_row = w_rowFull[ROW_W-1:0];

    assign o_inRange = !i_dx[11] && !i_dy[11]
                    && (w_colFull < 12'(COLS))
                    && (w_rowFull < 12'(ROWS));

endmodule

// File: rtl/alien_matrix_health.sv
// Alive-mask tracker for the invader matrix: turns collision pulses
// into per-alien kills, score events and the matrix-defeated pulse.
module alien_matrix_health
    import alien_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic        playGame,
    input  logic        hitValid,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic [10:0] topLeftX,
    input  logic [10:0] topLeftY,
    output logic [31:0] aliveMask,
    output logic [5:0]  aliensLeft,
    output logic        killPulse,
    output logic [6:0]  killPoints,
    output logic        matrixDefeated
);

    health_state_t    r_state;
    alien_mask_t      r_mask;
    logic [5:0]       r_left;
    logic             r_hitLock;
    logic             r_killPulse;
    logic [6:0]       r_killPoints;
    logic             r_defeated;

    logic             r_s1Vld;
    logic [11:0]      r_dx;
    logic [11:0]      r_dy;

    logic [ROW_W-1:0] w_row;
    logic [COL_W-1:0] w_col;
    logic             w_inRange;
    logic [4:0]       w_idx;
    alien_mask_t      w_killBit;
    logic             w_accept;

    // S1: capture sign-extended offsets; a hit only enters while ACTIVE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1Vld <= 1'b0;
            r_dx    <= '0;
            r_dy    <= '0;
        end else begin
            r_s1Vld <= hitValid && playGame && (r_state == ACTIVE);
            r_dx    <= {pixelX[10], pixelX} - {topLeftX[10], topLeftX};
            r_dy    <= {pixelY[10], pixelY} - {topLeftY[10], topLeftY};
        end
    end

    alien_cell_decode u_decode (
        .i_dx      (r_dx),
        .i_dy      (r_dy),
        .o_row     (w_row),
        .o_col     (w_col),
        .o_inRange (w_inRange)
    );

    assign w_idx     = 5'(w_row) * 5'(COLS) + 5'(w_col);
    assign w_killBit = alien_mask_t'(1) << w_idx;

    // A stale S1 entry is dropped if the FSM has left ACTIVE meanwhile.
    assign w_accept = r_s1Vld && playGame && (r_state == ACTIVE)
                   && w_inRange && r_mask[w_idx] && !r_hitLock;

    // One kill per frame: lock on accept, release on frame start.
    always_ff @(posedge clk) begin
        if (reset || !playGame) begin
            r_hitLock <= 1'b0;
        end else if (w_accept) begin
            r_hitLock <= 1'b1;
        end else if (startOfFrame) begin
            r_hitLock <= 1'b0;
        end
    end

    // Wave FSM, alive mask, maintained count and registered kill outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_mask       <= FULL_MASK;
            r_left       <= FULL_COUNT;
            r_killPulse  <= 1'b0;
            r_killPoints <= '0;
            r_defeated   <= 1'b0;
        end else begin
            r_killPulse  <= w_accept;
            r_killPoints <= w_accept ? ROW_POINTS[w_row] : 7'd0;
            r_defeated   <= 1'b0;
            if (!playGame) begin
                r_state <= IDLE;
                r_mask  <= FULL_MASK;
                r_left  <= FULL_COUNT;
            end else begin
                unique case (r_state)
                    IDLE: r_state <= ACTIVE;
                    ACTIVE: begin
                        if (w_accept) begin
                            r_mask <= r_mask & ~w_killBit;
                            r_left <= r_left - 6'd1;
                            if (r_left == 6'd1) begin
                                r_state <= CLEARED;
                            end
                        end
                    end
                    CLEARED: begin
                        r_defeated <= 1'b1;
                        r_state    <= WAIT_SOF;
                    end
                    WAIT_SOF: begin
                        if (startOfFrame) begin
                            r_state <= ACTIVE;
                            r_mask  <= FULL_MASK;
                            r_left  <= FULL_COUNT;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // The counter is never recomputed, so it must track the mask exactly.
    a_left_matches_mask : assert property (
        @(posedge clk) disable iff (reset)
        r_left == 6'($countones(r_mask))
    );

    assign aliveMask      = r_mask;
    assign aliensLeft     = r_left;
    assign killPulse      = r_killPulse;
    assign killPoints     = r_killPoints;
    assign matrixDefeated = r_defeated;

endmodule

// File: tb/tb_alien_matrix_health.sv
// Directed bench for alien_matrix_health.
// Expected values are hand-derived from the matrix geometry.
module tb_alien_matrix_health;

    logic        clk;
    logic        reset;
    logic        startOfFrame;
    logic        playGame;
    logic        hitValid;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic [10:0] topLeftX;
    logic [10:0] topLeftY;
    logic [31:0] aliveMask;
    logic [5:0]  aliensLeft;
    logic        killPulse;
    logic [6:0]  killPoints;
    logic        matrixDefeated;

    int n_chk;
    int n_err;

    logic [31:0] exp_mask;
    int          exp_left;
    int          row_pts [4] = '{40, 30, 20, 10};

    alien_matrix_health dut (
        .clk            (clk),
        .reset          (reset),
        .startOfFrame   (startOfFrame),
        .playGame       (playGame),
        .hitValid       (hitValid),
        .pixelX         (pixelX),
        .pixelY         (pixelY),
        .topLeftX       (topLeftX),
        .topLeftY       (topLeftY),
        .aliveMask      (aliveMask),
        .aliensLeft     (aliensLeft),
        .killPulse      (killPulse),
        .killPoints     (killPoints),
        .matrixDefeated (matrixDefeated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // One-cycle hit; returns with outputs of that hit visible.
    task automatic hit(input int x, input int y);
        pixelX   = 11'(x);
        pixelY   = 11'(y);
        hitValid = 1'b1;
        tick();
        hitValid = 1'b0;
        tick();
    endtask

    task automatic sof();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    initial begin
        n_chk        = 0;
        n_err        = 0;
        reset        = 1'b1;
        startOfFrame = 1'b0;
        playGame     = 1'b0;
        hitValid     = 1'b0;
        pixelX       = '0;
        pixelY       = '0;
        topLeftX     = 11'd32;
        topLeftY     = 11'd80;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_mask", aliveMask, 32'hFFFF_FFFF);
        chk("rst_left", 32'(aliensLeft), 32'd32);
        chk("rst_pulse", 32'(killPulse), 32'd0);
        chk("rst_pts", 32'(killPoints), 32'd0);
        chk("rst_def", 32'(matrixDefeated), 32'd0);

        // 1: first kill, top-left alien
        playGame = 1'b1;
        tick();
        hit(40, 90);
        chk("t1_pulse", 32'(killPulse), 32'd1);
        chk("t1_pts", 32'(killPoints), 32'd40);
        chk("t1_mask", aliveMask, 32'hFFFF_FFFE);
        chk("t1_left", 32'(aliensLeft), 32'd31);
        tick();
        chk("t1_pulse_end", 32'(killPulse), 32'd0);
        chk("t1_pts_end", 32'(killPoints), 32'd0);

        // 2: second hit in the same frame is locked out
        hit(80, 90);
        chk("t2_lock_pulse", 32'(killPulse), 32'd0);
        chk("t2_lock_mask", aliveMask, 32'hFFFF_FFFE);
        sof();
        hit(80, 90);
        chk("t2_pulse", 32'(killPulse), 32'd1);
        chk("t2_mask", aliveMask, 32'hFFFF_FFFC);
        chk("t2_left", 32'(aliensLeft), 32'd30);

        // 3: out-of-range hits ignored and leave the lock clear
        sof();
        hit(20, 90);
        chk("t3_neg_pulse", 32'(killPulse), 32'd0);
        hit(300, 90);
        chk("t3_col8_pulse", 32'(killPulse), 32'd0);
        hit(40, 208);
        chk("t3_row4_pulse", 32'(killPulse), 32'd0);
        chk("t3_mask", aliveMask, 32'hFFFF_FFFC);
        hit(40, 120);
        chk("t3_unlock_pulse", 32'(killPulse), 32'd1);
        chk("t3_unlock_pts", 32'(killPoints), 32'd30);
        chk("t3_unlock_mask", aliveMask, 32'hFFFF_FEFC);
        sof();
        hit(40, 120);
        chk("t3_dead_pulse", 32'(killPulse), 32'd0);

        // 4: clear the whole wave, one kill per frame
        exp_mask = 32'hFFFF_FEFC;
        exp_left = 29;
        for (int b = 0; b < 32; b++) begin
            if (exp_mask[b]) begin
                sof();
                hit(32 + (b % 8) * 32 + 3, 80 + (b / 8) * 32 + 3);
                exp_mask[b] = 1'b0;
                exp_left--;
                chk("t4_pulse", 32'(killPulse), 32'd1);
                chk("t4_pts", 32'(killPoints), 32'(row_pts[b / 8]));
                chk("t4_mask", aliveMask, exp_mask);
                chk("t4_left", 32'(aliensLeft), 32'(exp_left));
                chk("t4_def_early", 32'(matrixDefeated), 32'd0);
            end
        end
        tick();
        chk("t4_def", 32'(matrixDefeated), 32'd1);
        chk("t4_def_pulse", 32'(killPulse), 32'd0);
        tick();
        chk("t4_def_once", 32'(matrixDefeated), 32'd0);
        hit(40, 90);
        chk("t4_wait_pulse", 32'(killPulse), 32'd0);
        chk("t4_wait_mask", aliveMask, 32'h0);
        chk("t4_wait_def", 32'(matrixDefeated), 32'd0);
        sof();
        chk("t4_reload_mask", aliveMask, 32'hFFFF_FFFF);
        chk("t4_reload_left", 32'(aliensLeft), 32'd32);

        // 5: drop playGame mid-wave with five dead
        for (int b = 0; b < 5; b++) begin
            sof();
            hit(32 + b * 32 + 3, 85);
        end
        chk("t5_mask_pre", aliveMask, 32'hFFFF_FFE0);
        chk("t5_left_pre", 32'(aliensLeft), 32'd27);
        playGame = 1'b0;
        tick();
        chk("t5_mask", aliveMask, 32'hFFFF_FFFF);
        chk("t5_left", 32'(aliensLeft), 32'd32);
        hit(40, 90);
        chk("t5_idle_pulse", 32'(killPulse), 32'd0);
        chk("t5_idle_mask", aliveMask, 32'hFFFF_FFFF);

        // 6: reset the cycle after hitValid flushes the pending hit
        playGame = 1'b1;
        tick();
        sof();
        pixelX   = 11'd40;
        pixelY   = 11'd90;
        hitValid = 1'b1;
        tick();
        hitValid = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_pulse", 32'(killPulse), 32'd0);
        chk("t6_mask", aliveMask, 32'hFFFF_FFFF);
        chk("t6_left", 32'(aliensLeft), 32'd32);
        tick();
        chk("t6_pulse_late", 32'(killPulse), 32'd0);
        chk("t6_mask_late", aliveMask, 32'hFFFF_FFFF);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
